// File: rtl/serial_tx_if.sv
// Transaction request, shared timebase and serial line for serial_tx.
// The slave modport is the transmitter; the master side drives requests and cnt.
interface serial_tx_if #(
    parameter int P_DATA_WIDTH = 256
) ();
    logic                    start;
    logic [P_DATA_WIDTH-1:0] data;
    logic [7:0]              nbits;
    logic [31:0]             n0;
    logic [31:0]             n1;
    logic [31:0]             cnt;
    logic                    y;
    logic                    busy;
    logic                    done;

    modport master (
        output start, data, nbits, n0, n1, cnt,
        input  y, busy, done
    );

    modport slave (
        input  start, data, nbits, n0, n1, cnt,
        output y, busy, done
    );
endinterface

// File: rtl/serial_tx.sv
// Timebase-locked serial transmitter: MSB-first bit cells of n1 counts starting at cnt==n0.
// Define SERIAL_TX_PARITY_EN to append an even-parity cell (TAIL state) after the data bits.
module serial_tx #(
    parameter logic P_Y_INIT     = 1'b0,
    parameter int   P_DATA_WIDTH = 256
) (
    input logic        clk,
    input logic        rst_n,
    serial_tx_if.slave bus
);
    localparam int NW = $clog2(P_DATA_WIDTH + 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, SHIFT = 2'd2, TAIL = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, SHIFT = 2'd2} state_t;
`endif

    state_t                  state_q, state_d;
    logic [P_DATA_WIDTH-1:0] data_q, data_d;
    logic [NW-1:0]           nbits_q, nbits_d;
    logic [31:0]             n0_q, n0_d;
    logic [31:0]             n1_q, n1_d;
    logic [NW-1:0]           idx_q, idx_d;
    logic [31:0]             target_q, target_d;
    logic                    y_q, y_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
    logic                    par_q, par_d;
`endif

    logic [NW-1:0]           nbits_clamp;
    logic [NW-1:0]           sel;
    logic [P_DATA_WIDTH-1:0] shifted;
    logic                    bit_sel;

    always_comb begin
        if (bus.nbits == 8'd0)
            nbits_clamp = NW'(1);
        else if (int'(bus.nbits) > P_DATA_WIDTH)
            nbits_clamp = NW'(P_DATA_WIDTH);
        else
            nbits_clamp = NW'(bus.nbits);
    end

    // next bit to send is data[nbits-1-idx]; a shift avoids an oversized bit-select index
    assign sel     = nbits_q - idx_q - 1'b1;
    assign shifted = data_q >> sel;
    assign bit_sel = shifted[0];

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        nbits_d  = nbits_q;
        n0_d     = n0_q;
        n1_d     = n1_q;
        idx_d    = idx_q;
        target_d = target_q;
        y_d      = y_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            IDLE: begin
                y_d    = P_Y_INIT;
                busy_d = 1'b0;
                // done_q high means the previous transaction ends this clk; its start is dropped
                if (bus.start && !done_q) begin
                    data_d  = bus.data;
                    nbits_d = nbits_clamp;
                    n0_d    = (bus.n0 == 32'd0) ? 32'd1 : bus.n0;
                    n1_d    = (bus.n1 == 32'd0) ? 32'd1 : bus.n1;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (bus.cnt == n0_q) begin
                    y_d      = bit_sel;
                    idx_d    = NW'(1);
                    target_d = bus.cnt + n1_q;
                    state_d  = SHIFT;
`ifdef SERIAL_TX_PARITY_EN
                    par_d    = bit_sel;
`endif
                end
            end
            SHIFT: begin
                if (bus.cnt == target_q) begin
                    if (idx_q < nbits_q) begin
                        y_d      = bit_sel;
                        idx_d    = idx_q + 1'b1;
                        target_d = target_q + n1_q;
`ifdef SERIAL_TX_PARITY_EN
                        par_d    = par_q ^ bit_sel;
`endif
                    end else begin
`ifdef SERIAL_TX_PARITY_EN
                        y_d      = par_q;
                        target_d = target_q + n1_q;
                        state_d  = TAIL;
`else
                        y_d      = P_Y_INIT;
                        done_d   = 1'b1;
                        state_d  = IDLE;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            TAIL: begin
                if (bus.cnt == target_q) begin
                    y_d     = P_Y_INIT;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            data_q   <= '0;
            nbits_q  <= '0;
            n0_q     <= '0;
            n1_q     <= '0;
            idx_q    <= '0;
            target_q <= '0;
            y_q      <= P_Y_INIT;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            nbits_q  <= nbits_d;
            n0_q     <= n0_d;
            n1_q     <= n1_d;
            idx_q    <= idx_d;
            target_q <= target_d;
            y_q      <= y_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign bus.y    = y_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
